// File: rtl/mod_74x32_3.sv
// mod_74x32_3: three sections of a 74x32 quad 2-input OR package.
//
// Y[n] = A[n] | B[n] for each gate, purely combinational. Bit 0 is gate 1,
// bit 1 is gate 2 and bit 2 is gate 3. With [0:2] ordering, bit 0 is the
// leftmost (MSB) position, so A = 3'b100 drives gate 1 only.
//
// Build option MOD_74X32_3_REG_EN:
//   defined   - Y_R is a flopped copy of Y, and CHG pulses for one cycle on
//               the edge where Y_R takes a new value. Both clear
//               asynchronously while rst is high.
//   undefined - Y_R is wired straight to Y, CHG is tied low, clk and rst are
//               unused, and the block contains no flops.
// Y behaves the same in both builds. rst never forces Y.

module mod_74x32_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:2] A,
    input  logic [0:2] B,
    output logic [0:2] Y,
    output logic [0:2] Y_R,
    output logic       CHG
);

    // Three independent OR gates. X/Z on an input propagates through '|'
    // exactly as written, with no masking.
    always_comb begin
        Y = A | B;
    end

`ifdef MOD_74X32_3_REG_EN

    // Registered copy of Y and change flag. CHG compares the incoming Y with
    // the Y_R value being replaced, so it is high for exactly the cycle
    // following an edge that loaded a different value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_R <= 3'b000;
            CHG <= 1'b0;
        end else begin
            // NOTE: both flops use non-blocking assignments, so CHG sees the
            // old Y_R here even though Y_R is written in the same block.
            CHG <= (Y != Y_R);
            Y_R <= Y;
        end
    end

`else

    // Unregistered build: Y_R follows Y directly and there is never a change
    // pulse.
    always_comb begin
        Y_R = Y;
        CHG = 1'b0;
    end

    // clk and rst stay on the port list so both builds share one footprint.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

`endif

endmodule

// File: tb/tb_mod_74x32_3.sv
// tb_mod_74x32_3: directed bench for mod_74x32_3.
//
// Expected values are queued when the inputs are driven. They are popped and
// compared once the DUT output is due: 20 time units later for Y, or #1 after
// the clock edge for Y_R and CHG. The bench follows the build macro
// MOD_74X32_3_REG_EN to pick the registered or pass-through expectations.

`timescale 1ns/1ps

module tb_mod_74x32_3;

    logic       clk;
    logic       rst;
    logic [0:2] A;
    logic [0:2] B;
    logic [0:2] Y;
    logic [0:2] Y_R;
    logic       CHG;

    logic       clk_en;
    int         n_checks;
    int         n_pass;

    typedef struct {
        string      tag;
        logic [0:2] y;
        logic [0:2] y_r;
        logic       chg;
    } exp_t;

    exp_t sb[$];

    mod_74x32_3 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Y   (Y),
        .Y_R (Y_R),
        .CHG (CHG)
    );

    // Clock only toggles while clk_en is set, so the gate tests run clockless.
    initial begin
        clk = 1'b0;
        forever #5 if (clk_en) clk = ~clk;
    end

    // Bound on the whole run in case something stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [0:2] got, input logic [0:2] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, got, want);
    endtask

    task automatic push(input string tag, input logic [0:2] y,
                        input logic [0:2] y_r, input logic chg);
        exp_t e;
        e.tag = tag;
        e.y   = y;
        e.y_r = y_r;
        e.chg = chg;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare all three outputs against it.
    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_y"},   Y,             e.y);
            check({e.tag, "_y_r"}, Y_R,           e.y_r);
            check({e.tag, "_chg"}, {2'b00, CHG},  {2'b00, e.chg});
        end
    endtask

    // Expected Y_R while rst is held high and no clock runs.
    function automatic logic [0:2] idle_y_r(input logic [0:2] y);
`ifdef MOD_74X32_3_REG_EN
        return 3'b000;
`else
        return y;
`endif
    endfunction

    // Drive a combinational pattern, queue the expectation, and check 20 units later.
    task automatic comb_step(input string tag, input logic [0:2] a,
                             input logic [0:2] b, input logic [0:2] want_y);
        A = a;
        B = b;
        push(tag, want_y, idle_y_r(want_y), 1'b0);
        #20;
        pop_compare();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        A        = 3'b000;
        B        = 3'b000;

        // Reset state while no clock runs.
        push("reset", 3'b000, 3'b000, 1'b0);
        #20;
        pop_compare();

        // Gate 1 (bit 0, leftmost). rst stays high to show it never forces Y.
        comb_step("g1_11", 3'b100, 3'b100, 3'b100);
        comb_step("g1_01", 3'b000, 3'b100, 3'b100);
        comb_step("g1_10", 3'b100, 3'b000, 3'b100);
        comb_step("g1_00", 3'b000, 3'b000, 3'b000);
        // Gate 2 (bit 1).
        comb_step("g2_11", 3'b010, 3'b010, 3'b010);
        comb_step("g2_01", 3'b000, 3'b010, 3'b010);
        comb_step("g2_10", 3'b010, 3'b000, 3'b010);
        comb_step("g2_00", 3'b000, 3'b000, 3'b000);
        // Gate 3 (bit 2).
        comb_step("g3_11", 3'b001, 3'b001, 3'b001);
        comb_step("g3_01", 3'b000, 3'b001, 3'b001);
        comb_step("g3_10", 3'b001, 3'b000, 3'b001);
        comb_step("g3_00", 3'b000, 3'b000, 3'b000);

        // Exhaustive check of all 64 A/B pairs.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] ab;
            logic [0:2] a;
            logic [0:2] b;
            ab = i[5:0];
            a  = ab[5:3];
            b  = ab[2:0];
            comb_step($sformatf("ex_%0d", i), a, b, a | b);
        end

        // Registered path: start the clock with rst held high.
        A      = 3'b000;
        B      = 3'b000;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push("rst_clk", 3'b000, 3'b000, 1'b0);
        pop_compare();

        // Release rst and drive 101|010 between edges.
        @(negedge clk);
        rst = 1'b0;
        A   = 3'b101;
        B   = 3'b010;
`ifdef MOD_74X32_3_REG_EN
        push("rel_edge1", 3'b111, 3'b111, 1'b1);
        push("rel_edge2", 3'b111, 3'b111, 1'b0);
`else
        push("rel_edge1", 3'b111, 3'b111, 1'b0);
        push("rel_edge2", 3'b111, 3'b111, 1'b0);
`endif
        @(posedge clk);
        #1;
        pop_compare();
        @(posedge clk);
        #1;
        pop_compare();

        // Async reset between edges clears Y_R and CHG; Y stays 111.
        #2;
        rst = 1'b1;
        push("async_rst", 3'b111, idle_y_r(3'b111), 1'b0);
        #1;
        pop_compare();

        // Release again with Y=111: first edge loads and flags a change.
        @(negedge clk);
        rst = 1'b0;
`ifdef MOD_74X32_3_REG_EN
        push("rel2_edge", 3'b111, 3'b111, 1'b1);
`else
        push("rel2_edge", 3'b111, 3'b111, 1'b0);
`endif
        @(posedge clk);
        #1;
        pop_compare();

        // Change to 011: one CHG pulse, then quiet while inputs hold.
        @(negedge clk);
        A = 3'b011;
        B = 3'b000;
`ifdef MOD_74X32_3_REG_EN
        push("chg_edge", 3'b011, 3'b011, 1'b1);
`else
        push("chg_edge", 3'b011, 3'b011, 1'b0);
`endif
        push("hold_edge", 3'b011, 3'b011, 1'b0);
        @(posedge clk);
        #1;
        pop_compare();
        @(posedge clk);
        #1;
        pop_compare();

        // A glitch between edges is not captured by Y_R.
        @(negedge clk);
        A = 3'b100;
        #2;
        A = 3'b011;
        push("glitch_edge", 3'b011, 3'b011, 1'b0);
        @(posedge clk);
        #1;
        pop_compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
